// File: rtl/eth_txbuf_pkg.sv
// Shared types for the Ethernet TX store-and-forward buffer.
//   TXBUF_ENTRY_T : one stored beat {tlast, tkeep, tdata}
//   rd_state_t    : read-side (replay) FSM states
//   wr_state_t    : write-side (capture/drop) states
package eth_txbuf_pkg;

  typedef struct packed {
    logic        tlast;
    logic [7:0]  tkeep;
    logic [63:0] tdata;
  } TXBUF_ENTRY_T;

  localparam int ENTRY_W = $bits(TXBUF_ENTRY_T);

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_FETCH,
    RD_STREAM
  } rd_state_t;

  typedef enum logic {
    WR_PASS,
    WR_DROP
  } wr_state_t;

endpackage

// File: rtl/eth_txbuf_sdpram.sv
// Simple dual-port RAM: one write port, one read port with a registered
// (1-cycle) read. No reset on the array or read register so it maps to
// block RAM.
//   clk   : clock
//   we    : write enable, waddr/wdata : write address/data
//   re    : read enable,  raddr       : read address
//   rdata : read data, valid the cycle after re
module eth_txbuf_sdpram #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 73
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/eth_tx_pkt_buffer.sv
// Store-and-forward frame buffer between the encapsulator and the 10G MAC
// TX AXI-S port. A frame is replayed only once its tlast beat is stored, so
// the MAC never sees a mid-frame gap. Frames that do not fit are dropped
// whole and counted; the input is never back-pressured.
//   eth_clk/eth_rst : clock, asynchronous active-high reset
//   s_*             : AXI-S input from the encapsulator
//   m_*             : AXI-S output to the MAC (m_tuser tied 0)
//   stat_tx_frames  : frames fully emitted (wraps)
//   stat_drop_frames: frames dropped on overflow (wraps)
//   stat_drop_pulse : one-cycle pulse per drop decision
module eth_tx_pkt_buffer
  import eth_txbuf_pkg::*;
#(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic        eth_clk,
  input  logic        eth_rst,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic        s_tlast,
  input  logic [7:0]  s_tkeep,
  input  logic [63:0] s_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic [7:0]  m_tkeep,
  output logic [63:0] m_tdata,
  output logic        m_tuser,
  output logic [31:0] stat_tx_frames,
  output logic [31:0] stat_drop_frames,
  output logic        stat_drop_pulse
);

  typedef logic [DEPTH_LOG2-1:0] ptr_t;

  ptr_t         wr_ptr, wr_ptr_next, commit_ptr, commit_ptr_next, rd_ptr;
  ptr_t         frames_ready, frames_ready_next, wr_ptr_inc;
  wr_state_t    wr_state, wr_state_next;
  rd_state_t    rd_state, rd_state_next;
  logic         accept, full, ram_we, commit, drop;
  logic         ram_re, tx_done, q_valid, read_done, skid_valid, held, room;
  TXBUF_ENTRY_T ram_q, out_entry, skid_entry, wr_entry;

  assign accept     = s_tvalid && s_tready;
  assign wr_ptr_inc = wr_ptr + ptr_t'(1);
  assign full       = (wr_ptr_inc == rd_ptr);
  assign wr_entry   = '{tlast: s_tlast, tkeep: s_tkeep, tdata: s_tdata};

  eth_txbuf_sdpram #(
    .ADDR_W (DEPTH_LOG2),
    .DATA_W (ENTRY_W)
  ) u_ram (
    .clk   (eth_clk),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .re    (ram_re),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

  // Write side: capture beats, commit on tlast, rewind to commit_ptr on overflow.
  always_comb begin
    wr_state_next   = wr_state;
    wr_ptr_next     = wr_ptr;
    commit_ptr_next = commit_ptr;
    ram_we          = 1'b0;
    commit          = 1'b0;
    drop            = 1'b0;
    if (accept) begin
      unique case (wr_state)
        WR_PASS: begin
          if (full) begin
            drop        = 1'b1;
            wr_ptr_next = commit_ptr;
            // An overflowing tlast beat ends the frame immediately.
            if (!s_tlast) wr_state_next = WR_DROP;
          end else begin
            ram_we      = 1'b1;
            wr_ptr_next = wr_ptr_inc;
            if (s_tlast) begin
              commit          = 1'b1;
              commit_ptr_next = wr_ptr_inc;
            end
          end
        end
        WR_DROP: if (s_tlast) wr_state_next = WR_PASS;
        default: wr_state_next = WR_PASS;
      endcase
    end
  end

  assign tx_done = m_tvalid && m_tready && m_tlast;

  always_comb begin
    unique case ({commit, tx_done})
      2'b10:   frames_ready_next = frames_ready + ptr_t'(1);
      2'b01:   frames_ready_next = frames_ready - ptr_t'(1);
      default: frames_ready_next = frames_ready;
    endcase
  end

  // The output register plus skid hold at most two beats; a read may be
  // issued only if fewer than two will remain after this cycle's pop.
  assign held = m_tvalid && !m_tready;
  assign room = !((held && skid_valid) || (held && q_valid) || (skid_valid && q_valid));

  // Read side FSM. Reads within a frame stop once its tlast beat has come
  // back from RAM, so the pipeline never holds beats of the next frame.
  always_comb begin
    rd_state_next = rd_state;
    ram_re        = 1'b0;
    unique case (rd_state)
      RD_IDLE:  if (frames_ready != '0) rd_state_next = RD_FETCH;
      RD_FETCH: begin
        ram_re        = 1'b1;
        rd_state_next = RD_STREAM;
      end
      RD_STREAM: begin
        ram_re = !read_done && !(q_valid && ram_q.tlast) && room && (rd_ptr != commit_ptr);
        if (tx_done) rd_state_next = (frames_ready_next != '0) ? RD_FETCH : RD_IDLE;
      end
      default: rd_state_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge eth_clk or posedge eth_rst) begin
    if (eth_rst) begin
      wr_state <= WR_PASS;
      rd_state <= RD_IDLE;
    end else begin
      wr_state <= wr_state_next;
      rd_state <= rd_state_next;
    end
  end

  always_ff @(posedge eth_clk or posedge eth_rst) begin
    if (eth_rst) begin
      s_tready         <= 1'b0;
      wr_ptr           <= '0;
      commit_ptr       <= '0;
      rd_ptr           <= '0;
      frames_ready     <= '0;
      q_valid          <= 1'b0;
      read_done        <= 1'b0;
      m_tvalid         <= 1'b0;
      out_entry        <= '0;
      skid_valid       <= 1'b0;
      skid_entry       <= '0;
      stat_tx_frames   <= '0;
      stat_drop_frames <= '0;
      stat_drop_pulse  <= 1'b0;
    end else begin
      s_tready     <= 1'b1;
      wr_ptr       <= wr_ptr_next;
      commit_ptr   <= commit_ptr_next;
      frames_ready <= frames_ready_next;
      if (ram_re) rd_ptr <= rd_ptr + ptr_t'(1);
      q_valid <= ram_re;

      if (rd_state == RD_FETCH)        read_done <= 1'b0;
      else if (q_valid && ram_q.tlast) read_done <= 1'b1;

      // Output register refills from the skid first to preserve order.
      if (!m_tvalid || m_tready) begin
        if (skid_valid) begin
          out_entry  <= skid_entry;
          m_tvalid   <= 1'b1;
          skid_valid <= q_valid;
          if (q_valid) skid_entry <= ram_q;
        end else if (q_valid) begin
          out_entry <= ram_q;
          m_tvalid  <= 1'b1;
        end else begin
          m_tvalid <= 1'b0;
        end
      end else if (q_valid) begin
        skid_entry <= ram_q;
        skid_valid <= 1'b1;
      end

      if (tx_done) stat_tx_frames <= stat_tx_frames + 32'd1;
      if (drop)    stat_drop_frames <= stat_drop_frames + 32'd1;
      stat_drop_pulse <= drop;
    end
  end

  assign m_tlast = out_entry.tlast;
  assign m_tkeep = out_entry.tkeep;
  assign m_tdata = out_entry.tdata;
  assign m_tuser = 1'b0;

endmodule

// File: tb/tb_eth_tx_pkt_buffer.sv
module tb_eth_tx_pkt_buffer;

  logic        eth_clk = 1'b0;
  logic        eth_rst;
  logic        s_tvalid, s_tready, s_tlast;
  logic [7:0]  s_tkeep;
  logic [63:0] s_tdata;
  logic        m_tvalid, m_tready, m_tlast, m_tuser;
  logic [7:0]  m_tkeep;
  logic [63:0] m_tdata;
  logic [31:0] stat_tx_frames, stat_drop_frames;
  logic        stat_drop_pulse;

  logic [72:0] exp_q[$];
  int          n_assert = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          first_valid_cyc, tlast_cyc, pulse_cnt, lat;
  bit          mon_en = 1'b0;
  bit          arm_lat = 1'b0;
  bit          in_frame = 1'b0;
  bit          prev_stall = 1'b0;
  logic [72:0] held;

  eth_tx_pkt_buffer #(.DEPTH_LOG2(4)) dut (
    .eth_clk          (eth_clk),
    .eth_rst          (eth_rst),
    .s_tvalid         (s_tvalid),
    .s_tready         (s_tready),
    .s_tlast          (s_tlast),
    .s_tkeep          (s_tkeep),
    .s_tdata          (s_tdata),
    .m_tvalid         (m_tvalid),
    .m_tready         (m_tready),
    .m_tlast          (m_tlast),
    .m_tkeep          (m_tkeep),
    .m_tdata          (m_tdata),
    .m_tuser          (m_tuser),
    .stat_tx_frames   (stat_tx_frames),
    .stat_drop_frames (stat_drop_frames),
    .stat_drop_pulse  (stat_drop_pulse)
  );

  always #5 eth_clk = ~eth_clk;
  always @(posedge eth_clk) cyc++;

  task automatic chk(input string tag, input logic [72:0] obs, input logic [72:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: scoreboard pop, gap-free and stall-stability checks.
  always @(negedge eth_clk) begin
    logic [72:0] e;
    if (!mon_en || eth_rst) begin
      in_frame   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("hold_stable", {m_tlast, m_tkeep, m_tdata}, held);
      if (in_frame) chk("no_gap", 73'(m_tvalid), 73'(1));
      if (arm_lat && m_tvalid) begin
        first_valid_cyc = cyc;
        arm_lat = 1'b0;
      end
      if (stat_drop_pulse) pulse_cnt++;
      if (m_tvalid && m_tready) begin
        n_assert++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL spurious_beat: observed %0h expected no beat", {m_tlast, m_tkeep, m_tdata});
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("beat_data", {m_tlast, m_tkeep, m_tdata}, e);
          $display("beat out: tlast=%0b tkeep=%02h tdata=%016h", m_tlast, m_tkeep, m_tdata);
        end
        in_frame = !m_tlast;
      end
      prev_stall = m_tvalid && !m_tready;
      held = {m_tlast, m_tkeep, m_tdata};
    end
  end

  task automatic send_frame(input int n, input bit sparse, input bit keep_exp,
                            input bit quiet, input logic [7:0] last_keep);
    logic [72:0] e;
    for (int b = 0; b < n; b++) begin
      if (quiet) chk("quiet_before_tlast", 73'(m_tvalid), 73'(0));
      e[63:0]  = {$urandom, $urandom};
      e[71:64] = (b == n - 1) ? last_keep : 8'($urandom);
      e[72]    = (b == n - 1);
      if (keep_exp) exp_q.push_back(e);
      s_tvalid = 1'b1;
      s_tlast  = e[72];
      s_tkeep  = e[71:64];
      s_tdata  = e[63:0];
      @(posedge eth_clk); #1;
      if (b == n - 1) tlast_cyc = cyc;
      if (sparse && b != n - 1) begin
        s_tvalid = 1'b0;
        @(posedge eth_clk); #1;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    $display("frame in: %0d beats, expected %s", n, keep_exp ? "emitted" : "dropped");
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || m_tvalid) && k < budget) begin
      @(posedge eth_clk); #1;
      k++;
    end
    chk("drain_pending", 73'(exp_q.size()), 73'(0));
  endtask

  initial begin
    eth_rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tkeep = '0; s_tdata = '0; m_tready = 1'b1;
    repeat (3) @(posedge eth_clk); #1;
    chk("reset_mdata", {m_tlast, m_tkeep, m_tdata}, 73'(0));
    chk("reset_flags", 73'({s_tready, m_tvalid, m_tuser, stat_drop_pulse}), 73'(0));
    chk("reset_stats", 73'({stat_tx_frames, stat_drop_frames}), 73'(0));
    eth_rst = 1'b0;
    #1 chk("tready_low_after_release", 73'(s_tready), 73'(0));
    @(posedge eth_clk); #1;
    chk("tready_rise", 73'(s_tready), 73'(1));
    mon_en = 1'b1;

    // 1: 7-beat frame, latency from tlast to first output beat.
    arm_lat = 1'b1;
    first_valid_cyc = -1;
    send_frame(7, 1'b0, 1'b1, 1'b0, 8'hFF);
    drain(100);
    lat = first_valid_cyc - tlast_cyc;
    chk("latency_1to3", 73'((lat >= 1 && lat <= 3) ? 1 : 0), 73'(1));
    chk("tx_frames_t1", 73'(stat_tx_frames), 73'(1));

    // 2: sparse 10-beat frame must not appear before its tlast.
    send_frame(10, 1'b1, 1'b1, 1'b1, 8'h0F);
    drain(100);
    chk("tx_frames_t2", 73'(stat_tx_frames), 73'(2));

    // 3: 6-beat frame with m_tready toggling 1,0,1,0.
    m_tready = 1'b0;
    send_frame(6, 1'b0, 1'b1, 1'b0, 8'h3F);
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) begin
      m_tready = (k % 2 == 0);
      @(posedge eth_clk); #1;
    end
    m_tready = 1'b1;
    drain(50);
    chk("tx_frames_t3", 73'(stat_tx_frames), 73'(3));

    // 4: output stalled, second 10-beat frame overflows and is dropped.
    m_tready = 1'b0;
    pulse_cnt = 0;
    send_frame(10, 1'b0, 1'b1, 1'b0, 8'h01);
    send_frame(10, 1'b0, 1'b0, 1'b0, 8'h07);
    repeat (5) @(posedge eth_clk); #1;
    chk("drop_frames_t4", 73'(stat_drop_frames), 73'(1));
    chk("drop_pulse_cnt_t4", 73'(pulse_cnt), 73'(1));
    chk("stalled_valid_t4", 73'(m_tvalid), 73'(1));
    m_tready = 1'b1;
    drain(100);
    repeat (20) @(posedge eth_clk); #1;
    chk("tx_frames_t4", 73'(stat_tx_frames), 73'(4));

    // 5: oversize frame (overflow on its tlast), then 3-beat and 15-beat frames.
    send_frame(16, 1'b0, 1'b0, 1'b0, 8'hFF);
    repeat (10) @(posedge eth_clk); #1;
    chk("drop_frames_t5", 73'(stat_drop_frames), 73'(2));
    chk("drop_pulse_cnt_t5", 73'(pulse_cnt), 73'(2));
    send_frame(3, 1'b0, 1'b1, 1'b0, 8'h1F);
    drain(100);
    send_frame(15, 1'b0, 1'b1, 1'b0, 8'h7F);
    drain(100);
    chk("tx_frames_t5", 73'(stat_tx_frames), 73'(6));
    chk("drop_frames_t5b", 73'(stat_drop_frames), 73'(2));

    // 6: asynchronous reset with frames in flight on both sides.
    mon_en = 1'b0;
    exp_q.delete();
    m_tready = 1'b0;
    send_frame(5, 1'b0, 1'b0, 1'b0, 8'hFF);
    for (int b = 0; b < 3; b++) begin
      s_tvalid = 1'b1; s_tlast = 1'b0; s_tkeep = 8'hFF; s_tdata = 64'(b);
      @(posedge eth_clk); #1;
    end
    repeat (4) @(posedge eth_clk); #1;
    chk("pre_reset_valid", 73'(m_tvalid), 73'(1));
    #2 eth_rst = 1'b1;
    #1;
    chk("async_rst_flags", 73'({s_tready, m_tvalid}), 73'(0));
    chk("async_rst_mdata", {m_tlast, m_tkeep, m_tdata}, 73'(0));
    chk("async_rst_stats", 73'({stat_tx_frames, stat_drop_frames}), 73'(0));
    s_tvalid = 1'b0;
    @(posedge eth_clk); #1;
    eth_rst = 1'b0;
    @(posedge eth_clk); #1;
    chk("post_rst_tready", 73'(s_tready), 73'(1));
    m_tready = 1'b1;
    mon_en = 1'b1;
    send_frame(4, 1'b0, 1'b1, 1'b0, 8'h03);
    drain(100);
    repeat (10) @(posedge eth_clk); #1;
    chk("tx_frames_t6", 73'(stat_tx_frames), 73'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
